can_tx_serializer: RTL and testbench

// CAN 2.0A/B frame transmitter downstream of the AHB CAN bridge. Consumes the cantintf.tox

---
 rtl/can_tx_serializer_if.sv | 28 ++
 rtl/can_tx_serializer.sv | 213 +++++++++++++++++++++
 tb/tb_can_tx_serializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_serializer_if.sv
// Bridge-side request/status bundle for the CAN transmit serializer.
// The bridge drives the request fields; the serializer drives txBit/busy/done.
interface can_tx_serializer_if;
    logic        startXmit;
    logic [63:0] xmitdata;
    logic [7:0]  quantaDiv;
    logic [5:0]  propQuanta;
    logic [5:0]  seg1Quanta;
    logic [3:0]  datalen;
    logic        format;
    logic [1:0]  frameType;
    logic [28:0] id;
    logic        txBit;
    logic        busy;
    logic        done;

    modport master (
        output startXmit, xmitdata, quantaDiv, propQuanta, seg1Quanta,
               datalen, format, frameType, id,
        input  txBit, busy, done
    );

    modport slave (
        input  startXmit, xmitdata, quantaDiv, propQuanta, seg1Quanta,
               datalen, format, frameType, id,
        output txBit, busy, done
    );
endinterface

// File: rtl/can_tx_serializer.sv
// CAN 2.0A/B frame transmitter: builds the frame, appends CRC-15, bit-stuffs
// SOF..CRC and drives the serial bit at the programmed bit rate.
module can_tx_serializer #(
    parameter int unsigned SEG2_QUANTA = 4,
    parameter int unsigned IFS_BITS    = 3
) (
    input  logic               HCLK,
    input  logic               HRESET,
    can_tx_serializer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_HDR, S_DATA, S_CRC, S_TAIL, S_IFS
    } state_t;

    state_t      state, state_n;
    logic [37:0] hdr_sr, hdr_sr_n;
    logic [63:0] data_sr, data_sr_n;
    logic [14:0] crc, crc_n;
    logic [7:0]  fcnt, fcnt_n;
    logic [2:0]  run, run_n;
    logic        stuff, stuff_n;
    logic        tx, tx_n;
    logic        busy_r, busy_n;
    logic        done_c;

    logic [7:0]  hdr_last;
    logic [7:0]  data_bits;
    logic [7:0]  qdiv_last;
    logic [7:0]  nq_last;
    logic [7:0]  qcnt, bcnt;
    logic        boundary;
    logic        rtr_in;
    logic        in_stuff_region;

    assign bus.txBit = tx;
    assign bus.busy  = busy_r;
    assign bus.done  = done_c;

    assign rtr_in          = (bus.frameType == 2'b01);
    assign boundary        = (state != S_IDLE) && (qcnt == qdiv_last) && (bcnt == nq_last);
    assign in_stuff_region = (state == S_SOF) || (state == S_HDR) ||
                             (state == S_DATA) || (state == S_CRC);

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    always_ff @(posedge HCLK) begin
        if (!HRESET) state <= S_IDLE;
        else         state <= state_n;
    end

    // Quantum/bit timing and per-frame configuration latched at start.
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            qcnt      <= '0;
            bcnt      <= '0;
            qdiv_last <= '0;
            nq_last   <= '0;
            hdr_last  <= '0;
            data_bits <= '0;
        end else if (state == S_IDLE) begin
            qcnt <= '0;
            bcnt <= '0;
            if (bus.startXmit) begin
                qdiv_last <= (bus.quantaDiv == 8'd0) ? 8'd0 : bus.quantaDiv - 8'd1;
                nq_last   <= 8'(bus.propQuanta) + 8'(bus.seg1Quanta) + 8'(SEG2_QUANTA);
                hdr_last  <= bus.format ? 8'd37 : 8'd17;
                if (rtr_in)             data_bits <= 8'd0;
                else if (bus.datalen[3]) data_bits <= 8'd64;
                else                     data_bits <= {2'b00, bus.datalen[2:0], 3'b000};
            end
        end else if (qcnt == qdiv_last) begin
            qcnt <= '0;
            bcnt <= (bcnt == nq_last) ? 8'd0 : bcnt + 8'd1;
        end else begin
            qcnt <= qcnt + 8'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            hdr_sr  <= '0;
            data_sr <= '0;
            crc     <= '0;
            fcnt    <= '0;
            run     <= '0;
            stuff   <= 1'b0;
            tx      <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            hdr_sr  <= hdr_sr_n;
            data_sr <= data_sr_n;
            crc     <= crc_n;
            fcnt    <= fcnt_n;
            run     <= run_n;
            stuff   <= stuff_n;
            tx      <= tx_n;
            busy_r  <= busy_n;
        end
    end

    // state/fcnt name the last field bit sent; a stuff bit leaves them untouched.
    always_comb begin
        logic nbit;
        state_n   = state;
        hdr_sr_n  = hdr_sr;
        data_sr_n = data_sr;
        crc_n     = crc;
        fcnt_n    = fcnt;
        run_n     = run;
        stuff_n   = stuff;
        tx_n      = tx;
        busy_n    = busy_r;
        done_c    = 1'b0;
        nbit      = 1'b1;

        if (state == S_IDLE) begin
            if (bus.startXmit) begin
                state_n   = S_SOF;
                busy_n    = 1'b1;
                tx_n      = 1'b0;
                run_n     = 3'd1;
                stuff_n   = 1'b0;
                fcnt_n    = '0;
                crc_n     = '0;
                data_sr_n = bus.xmitdata;
                if (bus.format)
                    hdr_sr_n = {bus.id[28:18], 2'b11, bus.id[17:0], rtr_in, 2'b00, bus.datalen};
                else
                    hdr_sr_n = {bus.id[10:0], rtr_in, 2'b00, bus.datalen, 20'h00000};
            end
        end else if (boundary) begin
            if (!stuff && in_stuff_region && run == 3'd5) begin
                stuff_n = 1'b1;
                tx_n    = ~tx;
                run_n   = 3'd1;
            end else begin
                stuff_n = 1'b0;
                case (state)
                    S_SOF: begin
                        state_n = S_HDR;
                        fcnt_n  = '0;
                        nbit    = hdr_sr[37];
                    end
                    S_HDR: begin
                        if (fcnt == hdr_last) begin
                            fcnt_n = '0;
                            if (data_bits != 8'd0) begin
                                state_n = S_DATA;
                                nbit    = data_sr[63];
                            end else begin
                                state_n = S_CRC;
                                nbit    = crc[14];
                            end
                        end else begin
                            fcnt_n   = fcnt + 8'd1;
                            hdr_sr_n = {hdr_sr[36:0], 1'b0};
                            nbit     = hdr_sr[36];
                        end
                    end
                    S_DATA: begin
                        if (fcnt == data_bits - 8'd1) begin
                            state_n = S_CRC;
                            fcnt_n  = '0;
                            nbit    = crc[14];
                        end else begin
                            fcnt_n    = fcnt + 8'd1;
                            data_sr_n = {data_sr[62:0], 1'b0};
                            nbit      = data_sr[62];
                        end
                    end
                    S_CRC: begin
                        if (fcnt == 8'd14) begin
                            state_n = S_TAIL;
                            fcnt_n  = '0;
                        end else begin
                            fcnt_n = fcnt + 8'd1;
                            crc_n  = {crc[13:0], 1'b0};
                            nbit   = crc[13];
                        end
                    end
                    S_TAIL: begin
                        if (fcnt == 8'd9) begin
                            state_n = S_IFS;
                            fcnt_n  = '0;
                        end else begin
                            fcnt_n = fcnt + 8'd1;
                        end
                    end
                    S_IFS: begin
                        if (fcnt == 8'(IFS_BITS - 1)) begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                            done_c  = 1'b1;
                        end else begin
                            fcnt_n = fcnt + 8'd1;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
                tx_n  = nbit;
                run_n = (nbit == tx) ? 3'(run + 3'd1) : 3'd1;
                if (state_n == S_HDR || state_n == S_DATA)
                    crc_n = crc_step(crc, nbit);
            end
        end
    end

endmodule

// File: tb/tb_can_tx_serializer.sv
// Self-checking bench for can_tx_serializer: table of frames run against a
// bit-list model with stuffing, plus glitch-start and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_can_tx_serializer;
    localparam int unsigned SEG2 = 1;
    localparam int unsigned IFS  = 3;

    logic HCLK = 1'b0;
    logic HRESET = 1'b0;
    always #5 HCLK = ~HCLK;

    can_tx_serializer_if bus();

    can_tx_serializer #(.SEG2_QUANTA(SEG2), .IFS_BITS(IFS)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [28:0] id;
        logic        fmt;
        logic [1:0]  ftype;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [7:0]  div;
        logic [5:0]  prop;
        logic [5:0]  seg1;
        int          core_len;   // expected unstuffed SOF..CRC length
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    logic exp_q[$];
    logic got[$];
    logic dq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [14:0] crc_of(input int n);
        logic [14:0] c;
        logic fb;
        c = '0;
        for (int i = 0; i < n; i++) begin
            fb = dq[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    // Expected on-wire bit sequence for one frame, pushed into the scoreboard queue.
    function automatic void build_frame(input vec_t v);
        logic core[$];
        logic [63:0] d;
        logic [14:0] c;
        logic rtr, fb, last;
        int nbytes, run;
        d = v.data;
        rtr = (v.ftype == 2'b01);
        core.push_back(1'b0);
        if (!v.fmt) begin
            for (int i = 10; i >= 0; i--) core.push_back(v.id[i]);
            core.push_back(rtr); core.push_back(1'b0); core.push_back(1'b0);
        end else begin
            for (int i = 28; i >= 18; i--) core.push_back(v.id[i]);
            core.push_back(1'b1); core.push_back(1'b1);
            for (int i = 17; i >= 0; i--) core.push_back(v.id[i]);
            core.push_back(rtr); core.push_back(1'b0); core.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) core.push_back(v.dlc[i]);
        nbytes = rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
        for (int b = 0; b < nbytes; b++)
            for (int j = 0; j < 8; j++) core.push_back(d[63 - 8*b - j]);
        c = '0;
        foreach (core[i]) begin
            fb = core[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) core.push_back(c[i]);
        last = 1'b1;
        run = 0;
        foreach (core[i]) begin
            exp_q.push_back(core[i]);
            if (core[i] == last) run++;
            else begin run = 1; last = core[i]; end
            if (run == 5) begin
                exp_q.push_back(~last);
                last = ~last;
                run = 1;
            end
        end
        for (int i = 0; i < 10 + int'(IFS); i++) exp_q.push_back(1'b1);
    endfunction

    task automatic run_frame(input vec_t v, input string tag, input int glitch_c, input int abort_c);
        int bt, nbits, c, budget, busy_cyc, done_cnt, done_at, mism, maxrun, run, i, region;
        logic b, last;
        exp_q.delete();
        got.delete();
        dq.delete();
        build_frame(v);
        nbits = exp_q.size();
        bt = (1 + int'(v.prop) + int'(v.seg1) + int'(SEG2)) * ((v.div == 8'd0) ? 1 : int'(v.div));
        budget = nbits * bt + 50;
        bus.id = v.id; bus.format = v.fmt; bus.frameType = v.ftype; bus.datalen = v.dlc;
        bus.xmitdata = v.data; bus.quantaDiv = v.div; bus.propQuanta = v.prop; bus.seg1Quanta = v.seg1;
        @(negedge HCLK) bus.startXmit = 1'b1;
        @(negedge HCLK) bus.startXmit = 1'b0;
        c = 0; busy_cyc = 0; done_cnt = 0; done_at = -1; mism = 0;
        while (bus.busy && c < budget) begin
            busy_cyc++;
            if (bus.done) begin done_cnt++; done_at = c; end
            if (c % bt == bt / 2) begin
                got.push_back(bus.txBit);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    if (b !== bus.txBit) mism++;
                end else mism++;
            end
            if (c == glitch_c) begin
                bus.id = ~v.id; bus.datalen = 4'd8; bus.startXmit = 1'b1;
            end else bus.startXmit = 1'b0;
            if (c == abort_c) begin
                HRESET = 1'b0;
                @(negedge HCLK);
                check({tag, " abort_txBit"}, bus.txBit, 1);
                check({tag, " abort_busy"}, bus.busy, 0);
                repeat (2) @(negedge HCLK);
                HRESET = 1'b1;
                @(negedge HCLK);
                return;
            end
            @(negedge HCLK);
            c++;
        end
        bus.startXmit = 1'b0;
        if (c >= budget) check({tag, " timeout"}, c, budget - 1);
        check({tag, " stream_mismatches"}, mism + exp_q.size(), 0);
        check({tag, " busy_cycles"}, busy_cyc, nbits * bt);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_at, nbits * bt - 1);
        region = got.size() - (10 + int'(IFS));
        maxrun = 0; run = 0; last = 1'b1;
        for (int k = 0; k < region; k++) begin
            if (got[k] === last) run++; else begin run = 1; last = got[k]; end
            if (run > maxrun) maxrun = run;
        end
        check({tag, " max_run_over_5"}, (maxrun > 5) ? maxrun : 0, 0);
        i = 0; run = 0; last = 1'b1;
        while (i < got.size() && dq.size() < v.core_len) begin
            b = got[i]; i++;
            dq.push_back(b);
            if (b === last) run++; else begin run = 1; last = b; end
            if (run == 5 && i < got.size()) begin last = got[i]; i++; run = 1; end
        end
        check({tag, " destuffed_len"}, dq.size(), v.core_len);
        check({tag, " tail_len"}, got.size() - i, 10 + int'(IFS));
        if (dq.size() == v.core_len)
            check({tag, " crc"}, crc_of(v.core_len - 15),
                  {dq[v.core_len-15], dq[v.core_len-14], dq[v.core_len-13], dq[v.core_len-12],
                   dq[v.core_len-11], dq[v.core_len-10], dq[v.core_len-9], dq[v.core_len-8],
                   dq[v.core_len-7], dq[v.core_len-6], dq[v.core_len-5], dq[v.core_len-4],
                   dq[v.core_len-3], dq[v.core_len-2], dq[v.core_len-1]});
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{29'h123, 1'b0, 2'b00, 4'd1, 64'h5500_0000_0000_0000, 8'd1, 6'd1, 6'd1, 42};
        vt[1] = '{29'h000, 1'b0, 2'b00, 4'd0, 64'h0, 8'd1, 6'd1, 6'd1, 34};
        vt[2] = '{29'h0ABCDEF1, 1'b1, 2'b01, 4'd8, 64'hDEAD_BEEF_0123_4567, 8'd1, 6'd1, 6'd1, 54};
        vt[3] = '{29'h1F0F0F0F, 1'b1, 2'b00, 4'd3, 64'hA5C3_3C00_0000_0000, 8'd0, 6'd2, 6'd1, 78};
        vt[4] = '{29'h7FF, 1'b0, 2'b10, 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2, 6'd1, 6'd2, 98};
        vt[5] = '{29'h2A5, 1'b0, 2'b11, 4'd2, 64'hFF00_1234_5678_9ABC, 8'd1, 6'd1, 6'd1, 50};

        bus.startXmit = 1'b0; bus.id = '0; bus.format = 1'b0; bus.frameType = 2'b00;
        bus.datalen = '0; bus.xmitdata = '0; bus.quantaDiv = 8'd1; bus.propQuanta = 6'd1;
        bus.seg1Quanta = 6'd1;
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
        check("reset_txBit", bus.txBit, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        HRESET = 1'b1;
        @(negedge HCLK);

        for (int k = 0; k < 6; k++) begin
            run_frame(vt[k], $sformatf("vec%0d", k), -1, -1);
            if (k == 1 && got.size() >= 6)
                check("stuff_first6", {got[0], got[1], got[2], got[3], got[4], got[5]}, 6'b000001);
            if (k == 2 && dq.size() >= 39) begin
                check("ext_srr_ide", {dq[12], dq[13]}, 2'b11);
                check("ext_rtr", dq[32], 1);
                check("ext_dlc", {dq[35], dq[36], dq[37], dq[38]}, 4'b1000);
            end
        end

        run_frame(vt[0], "glitch", 30, -1);
        run_frame(vt[0], "abort", -1, 89);
        run_frame(vt[0], "after_abort", -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
